// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: program RAM, PC and one-at-a-time issue/wait handshake to the core.
// Optional IFU_RETIRE_COUNT_EN adds a 32-bit retired-command counter output.
module instr_fetch_unit #(
   parameter int          DEPTH    = 64,
   parameter int          ADDR_W   = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [31:0]       prog_wdata,
   input  logic              start,
   output logic [31:0]       command,
   output logic              run,
   input  logic              done,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic [31:0]       pc,
   output logic              busy,
   output logic              halted,
   output logic              fault
`ifdef IFU_RETIRE_COUNT_EN
   ,
   output logic [31:0]       retire_cnt
`endif
);

   localparam int          CNT_W  = $clog2(MAX_WAIT + 1);
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HALT, S_FAULT
   } state_t;

   state_t             r_state;
   logic [31:0]        r_mem [DEPTH];
   logic [31:0]        r_command;
   logic [31:0]        r_pc;
   logic               r_run;
   logic               r_busy;
   logic               r_halted;
   logic               r_fault;
   logic [CNT_W-1:0]   r_wait_cnt;

   logic               w_stopped;
   logic               w_accept_start;
   logic               w_accept_done;
   logic               w_is_sys;
   logic [31:0]        w_next_pc;
   logic               w_bad_pc;

   assign w_stopped      = (r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_FAULT);
   assign w_accept_start = start && w_stopped;
   assign w_accept_done  = done && (r_state == S_WAIT);
   assign w_is_sys       = (r_command == ECALL) || (r_command == EBREAK);
   assign w_next_pc      = redirect_valid ? redirect_pc : (r_pc + 32'd4);
   // Anything at or beyond DEPTH*4 has a nonzero bit above the word index.
   assign w_bad_pc       = (w_next_pc[1:0] != 2'b00) || (w_next_pc[31:ADDR_W+2] != '0);

   // RAM is deliberately outside the reset domain so a program survives reset.
   always_ff @(posedge clk) begin
      if (prog_we && w_stopped)
         r_mem[prog_addr] <= prog_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_command  <= NOP;
         r_pc       <= RESET_PC;
         r_run      <= 1'b0;
         r_busy     <= 1'b0;
         r_halted   <= 1'b0;
         r_fault    <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_HALT, S_FAULT: begin
               if (start) begin
                  r_state  <= S_FETCH;
                  r_pc     <= RESET_PC;
                  r_busy   <= 1'b1;
                  r_halted <= 1'b0;
                  r_fault  <= 1'b0;
               end
            end
            S_FETCH: begin
               r_command <= r_mem[r_pc[ADDR_W+1:2]];
               r_run     <= 1'b1;
               r_state   <= S_ISSUE;
            end
            S_ISSUE: begin
               r_run      <= 1'b0;
               r_wait_cnt <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               if (done) begin
                  if (w_is_sys) begin
                     r_state  <= S_HALT;
                     r_busy   <= 1'b0;
                     r_halted <= 1'b1;
                  end else if (w_bad_pc) begin
                     r_state  <= S_FAULT;
                     r_busy   <= 1'b0;
                     r_fault  <= 1'b1;
                  end else begin
                     r_pc     <= w_next_pc;
                     r_state  <= S_FETCH;
                  end
               end else if (r_wait_cnt >= CNT_W'(MAX_WAIT - 1)) begin
                  r_state <= S_FAULT;
                  r_busy  <= 1'b0;
                  r_fault <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_run   <= 1'b0;
            end
         endcase
      end
   end

`ifdef IFU_RETIRE_COUNT_EN
   logic [31:0] r_retire_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_retire_cnt <= '0;
      else if (w_accept_start)
         r_retire_cnt <= '0;
      else if (w_accept_done)
         r_retire_cnt <= r_retire_cnt + 32'd1;
   end

   assign retire_cnt = r_retire_cnt;
`else
   logic w_unused;
   assign w_unused = w_accept_start ^ w_accept_done;
`endif

   assign command = r_command;
   assign run     = r_run;
   assign pc      = r_pc;
   assign busy    = r_busy;
   assign halted  = r_halted;
   assign fault   = r_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential run, redirect, illegal PC, timeout,
// program-port guard, same-edge load+start and asynchronous reset mid-WAIT.
module tb_instr_fetch_unit;

   localparam int DEPTH    = 64;
   localparam int ADDR_W   = 6;
   localparam int MAX_WAIT = 255;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              prog_we = 1'b0;
   logic [ADDR_W-1:0] prog_addr = '0;
   logic [31:0]       prog_wdata = '0;
   logic              start = 1'b0;
   logic [31:0]       command;
   logic              run;
   logic              done = 1'b0;
   logic              redirect_valid = 1'b0;
   logic [31:0]       redirect_pc = '0;
   logic [31:0]       pc;
   logic              busy;
   logic              halted;
   logic              fault;
`ifdef IFU_RETIRE_COUNT_EN
   logic [31:0]       retire_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int n;

   instr_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
      .start(start), .command(command), .run(run), .done(done), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .pc(pc), .busy(busy), .halted(halted), .fault(fault)
`ifdef IFU_RETIRE_COUNT_EN
      , .retire_cnt(retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish by 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      prog_we = 1'b1; prog_addr = a; prog_wdata = d;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Polls at negedges until run is seen; returns number of ticks waited.
   task automatic wait_run(output int cnt);
      cnt = 0;
      while (!run && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("run_seen", 32'(run), 32'd1);
   endtask

   // Called at the negedge where run is visible; done is raised three cycles later.
   task automatic give_done(input logic rv, input logic [31:0] rpc);
      tick();
      chk("run_one_pulse", 32'(run), 32'd0);
      tick();
      tick();
      done = 1'b1; redirect_valid = rv; redirect_pc = rpc;
      tick();
      done = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
   endtask

   initial begin
      // Reset values
      #23;
      chk("rst_command", command, 32'h0000_0013);
      chk("rst_run", 32'(run), 0);
      chk("rst_pc", pc, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_fault", 32'(fault), 0);
`ifdef IFU_RETIRE_COUNT_EN
      chk("rst_retire", retire_cnt, 0);
`endif
      tick();
      reset = 1'b1;
      tick();

      // Sequential run to ECALL
      load(0, 32'h00a0_0093);
      load(1, 32'hffc0_0113);
      load(2, 32'h0000_0073);
      pulse_start();
      chk("seq_busy", 32'(busy), 1);
      wait_run(n);
      chk("seq_start_lat", n, 1);
      chk("seq_cmd0", command, 32'h00a0_0093);
      chk("seq_pc0", pc, 32'h0);
      give_done(1'b0, 32'h0);
      wait_run(n);
      chk("seq_done_lat", n, 1);
      chk("seq_cmd1", command, 32'hffc0_0113);
      chk("seq_pc1", pc, 32'h4);
      give_done(1'b0, 32'h0);
      wait_run(n);
      chk("seq_cmd2", command, 32'h0000_0073);
      chk("seq_pc2", pc, 32'h8);
      give_done(1'b0, 32'h0);
      chk("seq_halted", 32'(halted), 1);
      chk("seq_busy_end", 32'(busy), 0);
      chk("seq_pc_end", pc, 32'h8);
`ifdef IFU_RETIRE_COUNT_EN
      chk("seq_retire", retire_cnt, 3);
`endif

      // Redirect to word 4
      load(4, 32'h0000_0073);
      pulse_start();
      chk("rdr_halt_clr", 32'(halted), 0);
      wait_run(n);
      chk("rdr_cmd0", command, 32'h00a0_0093);
      give_done(1'b1, 32'h10);
      wait_run(n);
      chk("rdr_cmd1", command, 32'h0000_0073);
      chk("rdr_pc1", pc, 32'h10);
      give_done(1'b0, 32'h0);
      chk("rdr_halted", 32'(halted), 1);
      chk("rdr_pc_end", pc, 32'h10);

      // Illegal PCs: misaligned and out of range
      pulse_start();
      wait_run(n);
      give_done(1'b1, 32'h6);
      chk("ill6_fault", 32'(fault), 1);
      chk("ill6_pc", pc, 32'h0);
      chk("ill6_busy", 32'(busy), 0);
      pulse_start();
      chk("ill_fault_clr", 32'(fault), 0);
      wait_run(n);
      give_done(1'b1, 32'h100);
      chk("ill100_fault", 32'(fault), 1);
      chk("ill100_pc", pc, 32'h0);
      chk("ill100_halted", 32'(halted), 0);

      // Timeout; a done during ISSUE must be ignored
      pulse_start();
      wait_run(n);
      done = 1'b1;
      tick();
      done = 1'b0;
      repeat (MAX_WAIT - 1) tick();
      chk("to_not_yet", 32'(fault), 0);
      chk("to_busy", 32'(busy), 1);
      tick();
      chk("to_fault", 32'(fault), 1);
      chk("to_busy_end", 32'(busy), 0);

      // Rerun from RESET_PC; writes while busy must not land
      pulse_start();
      wait_run(n);
      chk("rerun_pc", pc, 32'h0);
      chk("rerun_cmd", command, 32'h00a0_0093);
      tick();
      load(1, 32'hdead_beef);
      load(2, 32'h0000_0013);
      done = 1'b1;
      tick();
      done = 1'b0;
      wait_run(n);
      chk("guard_cmd1", command, 32'hffc0_0113);
      give_done(1'b0, 32'h0);
      wait_run(n);
      chk("guard_cmd2", command, 32'h0000_0073);
      give_done(1'b0, 32'h0);
      chk("guard_halted", 32'(halted), 1);

      // Write and start on the same edge
      prog_we = 1'b1; prog_addr = 0; prog_wdata = 32'h0010_0073; start = 1'b1;
      tick();
      prog_we = 1'b0; start = 1'b0;
      wait_run(n);
      chk("same_cmd", command, 32'h0010_0073);
      give_done(1'b0, 32'h0);
      chk("ebreak_halted", 32'(halted), 1);
      chk("ebreak_pc", pc, 32'h0);

      // Asynchronous reset mid-WAIT, late done ignored, RAM retained
      pulse_start();
      wait_run(n);
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_command", command, 32'h0000_0013);
      chk("arst_pc", pc, 0);
      chk("arst_run", 32'(run), 0);
      tick();
      reset = 1'b1;
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      chk("late_busy", 32'(busy), 0);
      chk("late_halted", 32'(halted), 0);
      chk("late_fault", 32'(fault), 0);
      chk("late_run", 32'(run), 0);
      pulse_start();
      wait_run(n);
      chk("ram_kept", command, 32'h0010_0073);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
